// File: rtl/program_memory.sv
// Parametrised instruction memory with a byte-stream program loader and a
// range-checked byte-address fetch port. Optional halt detection: PROGMEM_HALT_DETECT_EN.
module program_memory #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 32,
    parameter int                 MEM_DEPTH = 256,
    parameter int                 OUT_REG   = 0,
    parameter logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}}
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_load_start,
    input  logic                         i_load_valid,
    input  logic [7:0]                   i_load_byte,
    output logic                         o_load_ready,
    input  logic                         i_load_end,
    output logic                         o_load_done,
    output logic [$clog2(MEM_DEPTH):0]   o_prog_len,
    input  logic                         i_fetch_en,
    input  logic [NB_ADDR-1:0]           i_fetch_addr,
    output logic [NB_DATA-1:0]           o_instr,
    output logic                         o_instr_valid,
    output logic                         o_addr_err
);
    localparam int BYTES = NB_DATA / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int CW    = (BYTES > 1) ? BW : 1;
    localparam int AW    = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t             state, state_next;
    logic [AW:0]        ptr, ptr_next, ptr_inc;
    logic [CW-1:0]      byte_cnt, cnt_next;
    logic [NB_DATA-1:0] word_buf, buf_next, assembled, wdata;
    logic               we;
    logic               halt_hit;
    logic [NB_DATA-1:0] mem [MEM_DEPTH];

    assign ptr_inc = ptr + 1'b1;

    always_comb begin
        assembled = word_buf;
        assembled[byte_cnt*8 +: 8] = i_load_byte;
    end

`ifdef PROGMEM_HALT_DETECT_EN
    assign halt_hit = (assembled == HALT_WORD);
`else
    logic unused_halt;
    assign unused_halt = ^HALT_WORD;
    assign halt_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = byte_cnt;
        buf_next   = word_buf;
        we         = 1'b0;
        wdata      = assembled;
        case (state)
            IDLE, RUN: begin
                if (i_load_start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    buf_next   = '0;
                end
            end
            LOAD: begin
                if (i_load_start) begin
                    ptr_next = '0;
                    cnt_next = '0;
                    buf_next = '0;
                end else begin
                    if (i_load_valid) begin
                        if (byte_cnt == CW'(BYTES - 1)) begin
                            we       = 1'b1;
                            ptr_next = ptr_inc;
                            cnt_next = '0;
                            buf_next = '0;
                            if (ptr_inc[AW] || halt_hit)
                                state_next = RUN;
                        end else begin
                            buf_next = assembled;
                            cnt_next = byte_cnt + 1'b1;
                        end
                    end
                    // A full memory or a halt word wins over a coincident end pulse.
                    if (i_load_end && state_next == LOAD)
                        state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (i_load_start) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    buf_next   = '0;
                end else begin
                    if (byte_cnt != '0) begin
                        we       = 1'b1;
                        wdata    = word_buf;
                        ptr_next = ptr_inc;
                        cnt_next = '0;
                        buf_next = '0;
                    end
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            byte_cnt <= cnt_next;
            word_buf <= buf_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (we)
            mem[ptr[AW-1:0]] <= wdata;
    end

    assign o_load_ready = (state == LOAD);
    assign o_load_done  = (state == RUN);
    assign o_prog_len   = (state == RUN) ? ptr : '0;

    logic               accept, fetch_err;
    logic [AW-1:0]      fetch_idx;
    logic [NB_DATA-1:0] instr1;
    logic               valid1, err1;

    assign accept    = (state == RUN) && i_fetch_en;
    assign fetch_idx = AW'(i_fetch_addr >> BW);
    assign fetch_err = ((i_fetch_addr >> (BW + AW)) != '0) ||
                       ((i_fetch_addr & NB_ADDR'(BYTES - 1)) != '0);

    // Errored fetches return a NOP without touching the RAM.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            instr1 <= '0;
            valid1 <= 1'b0;
            err1   <= 1'b0;
        end else if (accept) begin
            valid1 <= 1'b1;
            err1   <= fetch_err;
            instr1 <= fetch_err ? '0 : mem[fetch_idx];
        end else begin
            valid1 <= 1'b0;
            err1   <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [NB_DATA-1:0] instr2;
            logic               valid2, err2;

            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    instr2 <= '0;
                    valid2 <= 1'b0;
                    err2   <= 1'b0;
                end else begin
                    valid2 <= valid1;
                    err2   <= err1;
                    if (valid1)
                        instr2 <= instr1;
                end
            end

            assign o_instr       = instr2;
            assign o_instr_valid = valid2;
            assign o_addr_err    = err2;
        end else begin : g_no_out_reg
            assign o_instr       = instr1;
            assign o_instr_valid = valid1;
            assign o_addr_err    = err1;
        end
    endgenerate
endmodule

// File: doc/program_memory.md
Name: program_memory

Overview:
- Parametrised instruction memory for the pipeline, replacing the fixed 32x64 single-write-port RAM.
- Adds a built-in byte-stream loader, so the debug/UART unit can stream a program in without addressing words.
- Adds byte-address fetch with range checking, selectable 1- or 2-cycle read latency, and a load/run state machine that blocks fetches while a program is being written.

Parameters:
- NB_DATA, 32, instruction word width; must be a multiple of 8.
- NB_ADDR, 32, fetch address width (byte address from the PC).
- MEM_DEPTH, 256, number of words; power of two, at least 2.
- OUT_REG, 0, 0 gives 1-cycle fetch latency; 1 adds an output register for 2-cycle latency.
- HALT_WORD, 32'hFFFFFFFF, halt instruction encoding (used only by the optional feature).

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_load_start  in  1  single-cycle pulse that begins a program load.
- i_load_valid  in  1  byte-stream valid.
- i_load_byte  in  8  program byte, little-endian within each word.
- o_load_ready  out  1  loader can accept a byte.
- i_load_end  in  1  single-cycle pulse that ends the stream.
- o_load_done  out  1  program loaded; memory is readable.
- o_prog_len  out  clog2(MEM_DEPTH)+1  number of words written.
- i_fetch_en  in  1  fetch request.
- i_fetch_addr  in  NB_ADDR  byte address.
- o_instr  out  NB_DATA  fetched instruction.
- o_instr_valid  out  1  o_instr corresponds to an accepted fetch.
- o_addr_err  out  1  accepted fetch was out of range or misaligned.

Behaviour:
- Reset is asynchronous, active-low, and applies to all registers. Memory contents are not reset. After reset:
  - state = IDLE.
  - Write pointer and byte counter = 0.
  - o_load_ready = 0, o_load_done = 0, o_prog_len = 0.
  - o_instr = 0, o_instr_valid = 0, o_addr_err = 0.
- State machine IDLE, LOAD, FLUSH, RUN:
  - IDLE: i_load_start -> LOAD.
  - LOAD: o_load_ready = 1.
    - Each byte with i_load_valid && o_load_ready is shifted into lane [byte_cnt].
    - When lane NB_DATA/8-1 is filled, the assembled word is written at the write pointer; pointer +1 and byte_cnt = 0 in the same cycle.
    - i_load_end -> FLUSH.
    - Pointer reaching MEM_DEPTH -> RUN. o_load_ready drops the cycle after the last write; further bytes are not accepted.
  - FLUSH: o_load_ready = 0.
    - If byte_cnt != 0, write the partial word with unfilled lanes = 0 and increment the pointer.
    - Next cycle -> RUN.
  - RUN: o_load_done = 1; o_prog_len = pointer.
    - i_load_start -> LOAD; clears the pointer, byte_cnt and o_load_done.
- Simultaneous i_load_valid and i_load_end in LOAD: the byte is accepted first, then the FSM moves to FLUSH.
- i_load_start while in LOAD or FLUSH restarts the load: pointer = 0, and any partial word is discarded.
- Fetch is accepted only when state = RUN and i_fetch_en = 1.
  - Word index = i_fetch_addr >> clog2(NB_DATA/8).
  - Out of range (index >= MEM_DEPTH) or misaligned (low address bits != 0): o_instr = 0 (NOP), o_addr_err = 1. The RAM is not read for an error.
  - o_instr_valid and o_addr_err are asserted 1 cycle after acceptance (OUT_REG=0) or 2 cycles after (OUT_REG=1).
  - Fetches outside RUN produce o_instr_valid = 0.
  - o_instr holds its last value when no fetch is issued.
- Back-to-back fetches give one result per cycle (fully pipelined).

Optional Feature:
- Macro: PROGMEM_HALT_DETECT_EN.
- Defined:
  - In LOAD, an assembled word equal to HALT_WORD is written, then the FSM goes directly to RUN.
  - Remaining stream bytes get o_load_ready = 0 until the next i_load_start.
  - o_prog_len includes the halt word.
- Undefined: HALT_WORD has no special meaning; only i_load_end or a full memory ends a load.

Test Plan:
- Reset mid-load: stream 6 bytes, deassert i_reset_n -> state IDLE, o_prog_len = 0, o_load_ready = 0, all outputs 0 immediately (asynchronous).
- Load bytes 0x13,0x00,0x00,0x00,0xB3,0x00,0x00,0x00 then i_load_end -> o_load_done = 1, o_prog_len = 2. Fetch at address 4 -> o_instr = 32'h000000B3, o_instr_valid 1 cycle later (OUT_REG=0) and 2 cycles later (OUT_REG=1).
- Partial word: 5 bytes 0x01..0x05 then i_load_end -> word1 = 32'h00000005, o_prog_len = 2.
- Range/alignment: fetch addr 1022 and 1024 with MEM_DEPTH=256 -> o_instr = 0 and o_addr_err = 1 for both. Fetch addr 1020 -> valid, no error.
- Fill: stream 4*MEM_DEPTH+4 bytes -> o_load_ready low after 1024 bytes, o_prog_len = 256, word 0 unchanged by the extra 4 bytes.
- With PROGMEM_HALT_DETECT_EN: stream word0, HALT_WORD, word2 -> o_prog_len = 2, word2 not accepted. Without the macro -> o_prog_len = 3 after i_load_end.
